// File: rtl/image_loader.sv
// image_loader
//
// Packs a stream of 16-bit input words (two 8-bit pixels each) into one
// full image row and writes each completed row into the original-image
// SRAM at its row address. After the final row of the frame has been
// written, a one-cycle done pulse tells the top-level controller that
// blurring can start.
//
// Parameters:
//   ROWS      rows per frame, also the SRAM depth
//   ROW_BITS  SRAM word width (one full row of pixels)
//   WORD_BITS input word width
//
// Ports:
//   clk       clock
//   rst_n     synchronous active-low reset
//   in_valid  input word is valid this cycle
//   in_data   [7:0] even pixel, [15:8] odd pixel
//   busy      frame load in progress
//   done      one-cycle pulse after the last row is written
//   img_we    SRAM write enable (one cycle per row)
//   img_addr  SRAM row address
//   img_din   SRAM write data (complete row)

module image_loader #(
    parameter int ROWS      = 480,
    parameter int ROW_BITS  = 5120,
    parameter int WORD_BITS = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [WORD_BITS-1:0]     in_data,
    output logic                     busy,
    output logic                     done,
    output logic                     img_we,
    output logic [$clog2(ROWS)-1:0]  img_addr,
    output logic [ROW_BITS-1:0]      img_din
);

    localparam int WPR    = ROW_BITS / WORD_BITS;
    localparam int CNT_W  = $clog2(WPR);
    localparam int ADDR_W = $clog2(ROWS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     wordCnt_q, wordCnt_d;
    logic [ADDR_W-1:0]    rowCnt_q, rowCnt_d;
    logic [ROW_BITS-1:0]  rowReg_q;

    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 imgWe_q, imgWe_d;
    logic [ADDR_W-1:0]    imgAddr_q, imgAddr_d;
    logic [ROW_BITS-1:0]  imgDin_q, imgDin_d;

    logic                 accept;
    logic                 rowDone;
    logic                 frameDone;

    // Next-state, counter and output logic. Words are accepted in IDLE and
    // LOAD but never in FLUSH. The last word of a row bypasses the row
    // register and is merged straight into the SRAM write data, so the
    // write goes out one cycle after that word and the next row can start
    // filling the row register without a stall.
    always_comb begin
        state_d   = state_q;
        wordCnt_d = wordCnt_q;
        rowCnt_d  = rowCnt_q;
        imgAddr_d = imgAddr_q;
        imgDin_d  = imgDin_q;

        accept    = in_valid && (state_q != FLUSH);
        rowDone   = accept && (wordCnt_q == CNT_W'(WPR - 1));
        frameDone = rowDone && (rowCnt_q == ADDR_W'(ROWS - 1));

        if (accept) begin
            if (rowDone) begin
                wordCnt_d = '0;
                rowCnt_d  = frameDone ? '0 : rowCnt_q + 1'b1;
            end else begin
                wordCnt_d = wordCnt_q + 1'b1;
            end
        end

        case (state_q)
            IDLE:    if (accept)    state_d = LOAD;
            LOAD:    if (frameDone) state_d = FLUSH;
            FLUSH:                  state_d = IDLE;
            default:                state_d = IDLE;
        endcase

        if (rowDone) begin
            imgAddr_d = rowCnt_q;
            imgDin_d  = {in_data, rowReg_q[ROW_BITS-WORD_BITS-1:0]};
        end

        imgWe_d = rowDone;
        busy_d  = (state_d != IDLE);
        done_d  = (state_q == FLUSH);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wordCnt_q <= '0;
            rowCnt_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            imgWe_q   <= 1'b0;
            imgAddr_q <= '0;
            imgDin_q  <= '0;
        end else begin
            state_q   <= state_d;
            wordCnt_q <= wordCnt_d;
            rowCnt_q  <= rowCnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            imgWe_q   <= imgWe_d;
            imgAddr_q <= imgAddr_d;
            imgDin_q  <= imgDin_d;
        end
    end

    // Row assembly register. It is never cleared: every slot is rewritten
    // before the row is used, and a row interrupted by reset is simply
    // overwritten by the next frame.
    always_ff @(posedge clk) begin
        if (accept) begin
            rowReg_q[wordCnt_q*WORD_BITS +: WORD_BITS] <= in_data;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign img_we   = imgWe_q;
    assign img_addr = imgAddr_q;
    assign img_din  = imgDin_q;

endmodule

// File: tb/tb_image_loader.sv
// Testbench for image_loader, using a reduced frame (5 rows of 4 words)
// so that several complete frames fit in a short run.

module tb_image_loader;

    localparam int ROWS     = 5;
    localparam int ROW_BITS = 64;
    localparam int WB       = 16;
    localparam int WPR      = ROW_BITS / WB;
    localparam int AW       = $clog2(ROWS);

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic [WB-1:0]       in_data;
    logic                busy;
    logic                done;
    logic                img_we;
    logic [AW-1:0]       img_addr;
    logic [ROW_BITS-1:0] img_din;

    logic [ROW_BITS-1:0] mem [ROWS];
    int                  weTotal;
    int                  doneTotal;
    int                  total;
    int                  bad;

    image_loader #(
        .ROWS      (ROWS),
        .ROW_BITS  (ROW_BITS),
        .WORD_BITS (WB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .busy     (busy),
        .done     (done),
        .img_we   (img_we),
        .img_addr (img_addr),
        .img_din  (img_din)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: captures a row on every edge where img_we is high.
    initial weTotal = 0;
    always @(posedge clk) begin
        if (img_we) begin
            mem[img_addr] <= img_din;
            weTotal++;
        end
    end

    // Counts done pulses, sampled away from the active edge.
    initial doneTotal = 0;
    always @(negedge clk) begin
        if (done) doneTotal++;
    end

    // Frame pattern: pixel p of row r is (r + p + seed) mod 256.
    function automatic logic [7:0] pix(input int r, input int p, input int seed);
        return 8'((r + p + seed) % 256);
    endfunction

    function automatic logic [WB-1:0] wordOf(input int r, input int w, input int seed);
        return {pix(r, 2*w+1, seed), pix(r, 2*w, seed)};
    endfunction

    function automatic logic [ROW_BITS-1:0] rowOf(input int r, input int seed);
        logic [ROW_BITS-1:0] v;
        v = '0;
        for (int w = 0; w < WPR; w++) v[w*WB +: WB] = wordOf(r, w, seed);
        return v;
    endfunction

    // Compares one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of input and returns 1 time unit after the edge.
    task automatic applyStimulus(input logic v, input logic [WB-1:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    // Streams one full frame, checking write timing and data per word,
    // then the done/busy behaviour and the resulting SRAM contents.
    task automatic runFrame(input int seed, input int gapPct, input bit holdValid);
        int startWe;
        startWe = weTotal;
        for (int r = 0; r < ROWS; r++) begin
            for (int w = 0; w < WPR; w++) begin
                while (gapPct > 0 && $urandom_range(99) < gapPct) begin
                    applyStimulus(1'b0, 16'($urandom));
                    checkOutput("gapWe", 64'(img_we), 64'(0));
                end
                applyStimulus(1'b1, wordOf(r, w, seed));
                checkOutput("busyHigh", 64'(busy), 64'(1));
                checkOutput("doneLow", 64'(done), 64'(0));
                if (w == WPR - 1) begin
                    checkOutput("rowWe", 64'(img_we), 64'(1));
                    checkOutput("rowAddr", 64'(img_addr), 64'(r));
                    checkOutput("rowDin", img_din, rowOf(r, seed));
                end else begin
                    checkOutput("earlyWe", 64'(img_we), 64'(0));
                end
            end
        end
        // FLUSH cycle: a word presented here must be dropped.
        applyStimulus(holdValid, 16'hDEAD);
        checkOutput("doneHigh", 64'(done), 64'(1));
        checkOutput("busyDrop", 64'(busy), 64'(0));
        checkOutput("weAfterFlush", 64'(img_we), 64'(0));
        checkOutput("frameWrites", 64'(weTotal - startWe), 64'(ROWS));
        for (int r = 0; r < ROWS; r++) begin
            checkOutput($sformatf("mem%0d", r), mem[r], rowOf(r, seed));
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset state.
        applyStimulus(1'b0, '0);
        applyStimulus(1'b0, '0);
        checkOutput("rstBusy", 64'(busy), 64'(0));
        checkOutput("rstDone", 64'(done), 64'(0));
        checkOutput("rstWe", 64'(img_we), 64'(0));
        checkOutput("rstAddr", 64'(img_addr), 64'(0));
        checkOutput("rstDin", img_din, 64'(0));
        rst_n = 1'b1;
        applyStimulus(1'b0, '0);
        checkOutput("idleBusy", 64'(busy), 64'(0));

        // Continuous frame; row 0 starts with words 0x0100, 0x0302, ...
        // in_valid stays high through FLUSH so the next frame follows at once.
        runFrame(0, 0, 1'b1);
        checkOutput("row0LowWord", mem[0][15:0], 64'h0100);
        checkOutput("row0HighWord", mem[0][63:48], 64'h0706);

        // Second frame with ~50% input gaps overwrites every row.
        runFrame(5, 50, 1'b0);

        // Partial frame interrupted by reset at row 2, word 2.
        for (int r = 0; r < 3; r++) begin
            for (int w = 0; w < ((r == 2) ? 2 : WPR); w++) begin
                applyStimulus(1'b1, wordOf(r, w, 20));
            end
        end
        rst_n = 1'b0;
        applyStimulus(1'b1, 16'hBEEF);
        rst_n = 1'b1;
        checkOutput("midRstBusy", 64'(busy), 64'(0));
        checkOutput("midRstWe", 64'(img_we), 64'(0));
        checkOutput("midRstAddr", 64'(img_addr), 64'(0));
        checkOutput("midRstDin", img_din, 64'(0));
        applyStimulus(1'b0, '0);
        applyStimulus(1'b0, '0);
        checkOutput("noPartialWrite", 64'(weTotal), 64'(2*ROWS + 2));
        checkOutput("partialRow2Kept", mem[2], rowOf(2, 5));

        // Fresh frame after reset starts at row 0.
        runFrame(9, 0, 1'b0);
        applyStimulus(1'b0, '0);
        checkOutput("donePulseEnd", 64'(done), 64'(0));
        applyStimulus(1'b0, '0);
        checkOutput("doneCount", 64'(doneTotal), 64'(3));
        checkOutput("writeCount", 64'(weTotal), 64'(3*ROWS + 2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
